// File: rtl/f8_mem_responder.sv
// Even/odd byte-bank memory for the f8 core. Reads are registered (1 cycle). The block also boot-loads memory from a valid/ready stream.
// The loader is never stalled: ready is constant while loading. Core write ports are honoured only while the core runs.
module f8_mem_responder #(
  parameter int          BANK_AW   = 14,
  parameter logic [15:0] LOAD_BASE = 16'h4000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:0] mem_read_addr_even,
  output logic [7:0]  mem_read_data_even,
  input  logic [14:0] mem_read_addr_odd,
  output logic [7:0]  mem_read_data_odd,
  input  logic [14:0] mem_write_addr_even,
  input  logic [7:0]  mem_write_data_even,
  input  logic        mem_write_en_even,
  input  logic [14:0] mem_write_addr_odd,
  input  logic [7:0]  mem_write_data_odd,
  input  logic        mem_write_en_odd,
  input  logic        cpu_trap,
  output logic        cpu_reset,
  input  logic [7:0]  load_data,
  input  logic        load_valid,
  input  logic        load_last,
  output logic        load_ready,
  input  logic        load_start,
  output logic [15:0] load_count,
  output logic        halted
);

  localparam int DEPTH = 1 << BANK_AW;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RUN   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [15:0] ptr;
  logic        accept, restart, core_wr;

  logic               we_even, we_odd;
  logic [BANK_AW-1:0] wa_even, wa_odd;
  logic [7:0]         wd_even, wd_odd;

  logic [7:0] mem_even [DEPTH];
  logic [7:0] mem_odd  [DEPTH];

  // Upper address bits beyond the bank depth alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_read_addr_even, mem_read_addr_odd,
                              mem_write_addr_even, mem_write_addr_odd, ptr};

  assign accept  = (state_q == ST_LOAD) && load_valid;
  assign restart = ((state_q == ST_RUN) || (state_q == ST_HALT)) && load_start;
  assign core_wr = (state_q == ST_RUN);

  assign load_ready = (state_q == ST_LOAD);
  assign cpu_reset  = (state_q != ST_RUN);
  assign halted     = (state_q == ST_HALT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  state_d = ST_LOAD;
      ST_LOAD:  if (load_valid && load_last) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_RUN;
      ST_RUN: begin
        if (load_start)    state_d = ST_LOAD;
        else if (cpu_trap) state_d = ST_HALT;
      end
      ST_HALT:  if (load_start) state_d = ST_LOAD;
      default:  state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= LOAD_BASE;
      load_count <= 16'd0;
    end else if (restart) begin
      ptr        <= LOAD_BASE;
      load_count <= 16'd0;
    end else if (accept) begin
      ptr        <= ptr + 16'd1;
      load_count <= load_count + 16'd1;
    end
  end

  // Loader owns the banks outside RUN; ptr[0] picks the lane.
  always_comb begin
    we_even = 1'b0;
    we_odd  = 1'b0;
    wa_even = ptr[BANK_AW:1];
    wa_odd  = ptr[BANK_AW:1];
    wd_even = load_data;
    wd_odd  = load_data;
    if (core_wr) begin
      we_even = mem_write_en_even;
      we_odd  = mem_write_en_odd;
      wa_even = mem_write_addr_even[BANK_AW-1:0];
      wa_odd  = mem_write_addr_odd[BANK_AW-1:0];
      wd_even = mem_write_data_even;
      wd_odd  = mem_write_data_odd;
    end else if (accept) begin
      we_even = ~ptr[0];
      we_odd  = ptr[0];
    end
  end

  always_ff @(posedge clk) begin
    if (we_even) mem_even[wa_even] <= wd_even;
    if (we_odd)  mem_odd[wa_odd]   <= wd_odd;
  end

  // Same-edge read of a word being written returns the old contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read_data_even <= 8'h00;
      mem_read_data_odd  <= 8'h00;
    end else begin
      mem_read_data_even <= mem_even[mem_read_addr_even[BANK_AW-1:0]];
      mem_read_data_odd  <= mem_odd[mem_read_addr_odd[BANK_AW-1:0]];
    end
  end

endmodule
